// File: rtl/viterbi_pkg.sv
// Shared definitions for the convolutional encoder / Viterbi decoder pair:
// FSM encoding, puncture mask width and the generator-parity helper.
package viterbi_pkg;

   localparam int unsigned PUNCT_MASK_W = 2 * 8;
   localparam int unsigned POLY_MAX_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } enc_state_e;

   function automatic logic f_parity(input logic [POLY_MAX_W-1:0] state,
                                     input logic [POLY_MAX_W-1:0] poly);
      return ^(state & poly);
   endfunction

endpackage

// File: rtl/punct_idx_cnt.sv
// Modulo-p_punct_period symbol index; presents the o_valid mask of the current
// symbol. A clear forces index 0 for the symbol emitted in the same cycle.
module punct_idx_cnt
   import viterbi_pkg::*;
#(
   parameter int unsigned             p_punct_period = 1,
   parameter logic [PUNCT_MASK_W-1:0] p_punct_mask   = 16'h0003
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       en_i,
   output logic [1:0] mask_o
);

   localparam int unsigned      IDX_W    = (p_punct_period > 1) ? $clog2(p_punct_period) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_punct_period - 1);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [IDX_W-1:0] idx_cur;
   logic [1:0]       mask_tbl [p_punct_period];

   if (p_punct_period < 1 || p_punct_period > 8) begin : g_bad_period
      $error("punct_idx_cnt: p_punct_period must be 1..8");
   end

   for (genvar g = 0; g < p_punct_period; g++) begin : g_tbl
      if (p_punct_mask[2*g +: 2] == 2'b00) begin : g_bad_mask
         $error("punct_idx_cnt: puncture mask entry must be nonzero");
      end
      assign mask_tbl[g] = p_punct_mask[2*g +: 2];
   end

   always_comb begin
      idx_cur = clr_i ? '0 : idx_q;
      idx_d   = idx_cur;
      if (en_i) begin
         idx_d = (idx_cur == IDX_LAST) ? '0 : idx_cur + IDX_W'(1);
      end
      mask_o = mask_tbl[idx_cur];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/conv_punct_enc.sv
// Rate-1/2 convolutional encoder with programmable puncturing and zero-tail
// frame termination; single registered symbol output with ready/valid handshake.
module conv_punct_enc
   import viterbi_pkg::*;
#(
   parameter int unsigned                p_size_polinom  = 3,
   parameter logic [p_size_polinom-1:0]  p_polinom_0     = 3'b111,
   parameter logic [p_size_polinom-1:0]  p_polinom_1     = 3'b101,
   parameter logic [p_size_polinom-1:0]  p_defoult_state = 3'b000,
   parameter int unsigned                p_punct_period  = 1,
   parameter logic [PUNCT_MASK_W-1:0]    p_punct_mask    = 16'h0003
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_data,
   input  logic       i_valid,
   input  logic       i_last,
   output logic       o_ready,
   output logic [1:0] o_data,
   output logic [1:0] o_valid,
   output logic       o_last,
   input  logic       i_ready
);

   localparam int unsigned K      = p_size_polinom;
   localparam int unsigned TAIL_W = $clog2(K) + 1;

   if (K < 2) begin : g_bad_k
      $error("conv_punct_enc: p_size_polinom must be >= 2");
   end

   enc_state_e        state_q, state_d;
   logic [K-1:0]      shift_q, shift_d;
   logic [TAIL_W-1:0] tail_q, tail_d;
   logic [1:0]        data_q, data_d;
   logic [1:0]        valid_q, valid_d;
   logic              last_q, last_d;

   logic              out_free;
   logic              accept;
   logic              emit;
   logic              cnt_clr;
   logic              enc_bit;
   logic [K-1:0]      s_base;
   logic [K-1:0]      s_new;
   logic [1:0]        parity;
   logic [1:0]        mask;

   assign out_free = (valid_q == 2'b00) || i_ready;
   assign o_ready  = !i_reset && (state_q != ST_FLUSH) && out_free;
   assign accept   = i_valid && o_ready;
   assign emit     = accept || ((state_q == ST_FLUSH) && out_free);

   punct_idx_cnt #(
      .p_punct_period (p_punct_period),
      .p_punct_mask   (p_punct_mask)
   ) u_punct_idx (
      .clk_i  (i_clk),
      .rst_i  (i_reset),
      .clr_i  (cnt_clr),
      .en_i   (emit),
      .mask_o (mask)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      tail_d  = tail_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      cnt_clr = 1'b0;
      s_base  = shift_q;
      enc_bit = i_data;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               s_base  = p_defoult_state;
               cnt_clr = 1'b1;
               state_d = i_last ? ST_FLUSH : ST_RUN;
               tail_d  = TAIL_W'(K - 1);
            end
         end
         ST_RUN: begin
            if (accept && i_last) begin
               state_d = ST_FLUSH;
               tail_d  = TAIL_W'(K - 1);
            end
         end
         ST_FLUSH: begin
            enc_bit = 1'b0;
            if (out_free) begin
               tail_d = tail_q - TAIL_W'(1);
               if (tail_q == TAIL_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      s_new     = {s_base[K-2:0], enc_bit};
      parity[0] = f_parity(POLY_MAX_W'(s_new), POLY_MAX_W'(p_polinom_0));
      parity[1] = f_parity(POLY_MAX_W'(s_new), POLY_MAX_W'(p_polinom_1));

      // A stalled symbol stays put; a consumed one is either replaced or cleared.
      if (emit) begin
         shift_d = s_new;
         data_d  = parity & mask;
         valid_d = mask;
         last_d  = (state_q == ST_FLUSH) && (tail_q == TAIL_W'(1));
      end else if (i_ready) begin
         data_d  = 2'b00;
         valid_d = 2'b00;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         shift_q <= p_defoult_state;
         tail_q  <= '0;
         data_q  <= 2'b00;
         valid_q <= 2'b00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         tail_q  <= tail_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_last  = last_q;

endmodule

// File: tb/tb_conv_punct_enc.sv
// Bench for conv_punct_enc: two instances (unpunctured and period-2 mask 0111)
// share stimulus; a scoreboard checks every consumed symbol.
module tb_conv_punct_enc;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_data, i_valid, i_last, i_ready;
   logic [1:0] od_a, ov_a, od_b, ov_b;
   logic       ol_a, ol_b, ordy_a, ordy_b;

   always #5 clk = ~clk;

   conv_punct_enc #(
      .p_size_polinom  (3),
      .p_polinom_0     (3'b111),
      .p_polinom_1     (3'b101),
      .p_defoult_state (3'b000),
      .p_punct_period  (1),
      .p_punct_mask    (16'h0003)
   ) dut_a (
      .i_clk (clk), .i_reset (rst), .i_data (i_data), .i_valid (i_valid),
      .i_last (i_last), .o_ready (ordy_a), .o_data (od_a), .o_valid (ov_a),
      .o_last (ol_a), .i_ready (i_ready)
   );

   conv_punct_enc #(
      .p_size_polinom  (3),
      .p_polinom_0     (3'b111),
      .p_polinom_1     (3'b101),
      .p_defoult_state (3'b000),
      .p_punct_period  (2),
      .p_punct_mask    (16'h0007)
   ) dut_b (
      .i_clk (clk), .i_reset (rst), .i_data (i_data), .i_valid (i_valid),
      .i_last (i_last), .o_ready (ordy_b), .o_data (od_b), .o_valid (ov_b),
      .o_last (ol_b), .i_ready (i_ready)
   );

   typedef struct {
      logic [1:0] d_a;
      logic [1:0] v_a;
      logic [1:0] d_b;
      logic [1:0] v_b;
      logic       last;
   } sym_t;

   typedef struct {
      int unsigned n;
      logic [7:0]  bits;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } vec_t;

   sym_t        exp_q[$];
   vec_t        vecs[4];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   bit          rand_mode = 1'b0;

   always @(negedge clk) cyc++;

   always @(negedge clk) begin
      if (rand_mode) i_ready = ($urandom_range(0, 3) != 0);
   end

   // Scoreboard: a symbol is consumed on a clock edge with o_valid != 0 and i_ready.
   always @(posedge clk) begin
      sym_t e;
      if (!rst && ov_a != 2'b00 && i_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_symbol: got a=%b/%b/%b b=%b/%b/%b, none expected",
                     od_a, ov_a, ol_a, od_b, ov_b, ol_b);
         end else begin
            e = exp_q.pop_front();
            if (od_a !== e.d_a || ov_a !== e.v_a || ol_a !== e.last ||
                od_b !== e.d_b || ov_b !== e.v_b || ol_b !== e.last) begin
               n_fail++;
               $display("FAIL symbol: got a=%b/%b/%b b=%b/%b/%b, expected a=%b/%b/%b b=%b/%b/%b",
                        od_a, ov_a, ol_a, od_b, ov_b, ol_b,
                        e.d_a, e.v_a, e.last, e.d_b, e.v_b, e.last);
            end
         end
      end
   end

   task automatic check(input string name, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_table(input vec_t v, input int unsigned nsym);
      sym_t        e;
      logic [15:0] ea, eb;
      ea = v.exp_a;
      eb = v.exp_b;
      for (int unsigned i = 0; i < nsym; i++) begin
         e.d_a  = ea[2*i +: 2];
         e.d_b  = eb[2*i +: 2];
         e.v_a  = 2'b11;
         e.v_b  = (i % 2 == 0) ? 2'b11 : 2'b01;
         e.last = (i == v.n + 1);
         exp_q.push_back(e);
      end
   endtask

   // Reference encoder: K=3, generators 111/101, zero tail, k restarts per frame.
   task automatic push_model(input logic [63:0] bits, input int unsigned n);
      logic [2:0] s;
      logic       b;
      sym_t       e;
      s = 3'b000;
      for (int unsigned i = 0; i < n + 2; i++) begin
         b      = (i < n) ? bits[i] : 1'b0;
         s      = {s[1:0], b};
         e.d_a  = {^(s & 3'b101), ^(s & 3'b111)};
         e.v_a  = 2'b11;
         e.v_b  = (i % 2 == 0) ? 2'b11 : 2'b01;
         e.d_b  = e.d_a & e.v_b;
         e.last = (i == n + 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_bit(input logic b, input logic last, output int unsigned acc_cyc);
      int unsigned guard;
      bit          ok;
      guard = 0;
      ok    = 1'b0;
      acc_cyc = 0;
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = b;
      i_last  = last;
      while (!ok && guard < 200) begin
         @(posedge clk);
         if (ordy_a) begin
            ok      = 1'b1;
            acc_cyc = cyc;
         end else begin
            guard++;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got o_ready=0 for 200 cycles, required 1");
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] bits, input int unsigned n);
      int unsigned c;
      for (int unsigned i = 0; i < n; i++) send_bit(bits[i], (i == n - 1), c);
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int unsigned c_last, c_first, c;
      logic [63:0] rbits;
      int unsigned rn;

      vecs[0] = '{n: 4, bits: 8'b0000_1101, exp_a: 16'h0E87, exp_b: 16'h0607};
      vecs[1] = '{n: 1, bits: 8'b0000_0001, exp_a: 16'h0037, exp_b: 16'h0037};
      vecs[2] = '{n: 3, bits: 8'b0000_0000, exp_a: 16'h0000, exp_b: 16'h0000};
      vecs[3] = '{n: 4, bits: 8'b0000_1011, exp_a: 16'h0D2B, exp_b: 16'h0523};

      rst = 1'b1; i_valid = 1'b0; i_data = 1'b0; i_last = 1'b0; i_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_valid", 32'(ov_a), 0);
      check("rst_o_data", 32'(od_a), 0);
      check("rst_o_last", 32'(ol_a), 0);
      check("rst_o_ready", 32'(ordy_a), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_o_ready", 32'(ordy_a), 1);

      for (int unsigned t = 0; t < 4; t++) begin
         push_table(vecs[t], vecs[t].n + 2);
         send_frame(64'(vecs[t].bits), vecs[t].n);
         go_idle();
         drain();
      end

      // Backpressure mid-frame: held symbol, no acceptance, same sequence.
      push_table(vecs[0], 6);
      send_bit(1'b1, 1'b0, c);
      send_bit(1'b0, 1'b0, c);
      @(negedge clk);
      i_ready = 1'b0;
      i_data  = 1'b1;
      for (int unsigned k = 0; k < 3; k++) begin
         @(posedge clk);
         check("stall_o_ready", 32'(ordy_a), 0);
         #1;
         check("stall_o_data", 32'(od_a), 32'h1);
         check("stall_o_valid", 32'(ov_a), 32'h3);
      end
      @(negedge clk);
      i_ready = 1'b1;
      i_valid = 1'b0;
      send_bit(1'b1, 1'b0, c);
      send_bit(1'b1, 1'b1, c);
      go_idle();
      drain();

      // Reset while the first tail symbol is presented.
      push_table(vecs[0], 4);
      send_frame(64'(vecs[0].bits), 4);
      go_idle();
      @(negedge clk);
      check("flush_o_data", 32'(od_a), 32'h2);
      check("flush_o_ready", 32'(ordy_a), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_o_valid", 32'(ov_a), 0);
      check("midrst_o_last", 32'(ol_a), 0);
      check("midrst_o_data", 32'(od_a), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_o_ready", 32'(ordy_a), 1);
      check("midrst_leftover", exp_q.size(), 0);
      push_table(vecs[1], 3);
      send_frame(64'(vecs[1].bits), 1);
      go_idle();
      drain();

      // Back-to-back frames: next frame's first bit accepted right after FLUSH exit.
      push_table(vecs[3], 6);
      push_table(vecs[1], 3);
      for (int unsigned i = 0; i < 4; i++) send_bit(vecs[3].bits[i], (i == 3), c_last);
      send_bit(1'b1, 1'b1, c_first);
      go_idle();
      check("b2b_gap_cycles", c_first - c_last, 3);
      drain();

      // Random frames with random downstream stalls, mostly back-to-back.
      rand_mode = 1'b1;
      for (int unsigned f = 0; f < 12; f++) begin
         rn    = $urandom_range(1, 20);
         rbits = {$urandom, $urandom};
         push_model(rbits, rn);
         send_frame(rbits, rn);
         if (f % 4 == 3) go_idle();
      end
      go_idle();
      drain();
      rand_mode = 1'b0;
      @(negedge clk);
      i_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
